snake_head_driver: RTL
======================

Name: snake_head_driver

Overview:
- Upstream stage of the wall collision checker in the SGA snake game.
- Owns the snake head position on the 4x4 grid and the current heading.
- Turns player button presses into a committed direction, advancing the head one cell every MOVE_PERIOD clocks.
- Consumes the registered colide flag from the collision checker to end the game.

Parameters:
MOVE_PERIOD, 25_000_000, clocks per head step; must be >= 3
START_HEAD, 4'b0000, head cell after reset or restart; [3:2]=row, [1:0]=column
START_DIR, 2'b00, heading after reset or restart

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  begin game from IDLE; restart from GAME_OVER
btn_right  input  1  request RIGHT (2'b00)
btn_left  input  1  request LEFT (2'b01)
btn_down  input  1  request DOWN (2'b10)
btn_up  input  1  request UP (2'b11)
colide  input  1  registered collision flag from the collision checker; reflects head/direction of the previous cycle
head  output  4  current head cell, registered
direction  output  2  committed heading of the next step, registered
move_tick  output  1  one-cycle pulse in the first cycle the new head is visible
running  output  1  high in RUNNING
game_over  output  1  high in GAME_OVER

Behaviour:
- Reset (reset==0 at a clock edge), regardless of state:
  - head=START_HEAD, direction=START_DIR, next_dir=START_DIR.
  - cnt=0, state=IDLE.
  - move_tick=0, running=0, game_over=0.
- FSM states: IDLE, RUNNING, GAME_OVER.
  - IDLE: head/direction held at their start values; colide and buttons ignored. start=1 -> RUNNING with cnt=0.
  - RUNNING: cnt counts 0..MOVE_PERIOD-1 and wraps.
  - GAME_OVER: head and direction frozen; buttons and colide ignored. start=1 -> IDLE, which reloads START_HEAD, START_DIR and next_dir. A further start is needed to run.
- Button capture, every RUNNING cycle:
  - Priority when several are high: up > down > left > right.
  - The candidate is rejected if it is the opposite of direction (same bit[1], different bit[0]).
  - Otherwise next_dir <= candidate. The last accepted press wins.
- Commit: at cnt==MOVE_PERIOD-3, direction <= next_dir. This gives the collision checker one full cycle to register colide before the step.
- Step, at cnt==MOVE_PERIOD-1:
  - colide==1 -> GAME_OVER; head unchanged; no move_tick.
  - colide==0 -> head updated per direction:
    - RIGHT: column+1.
    - LEFT: column-1.
    - DOWN: row+1.
    - UP: row-1.
    - 2-bit arithmetic; the other field is unchanged.
  - On a step, move_tick=1 in the following cycle.
- No wrap-around is ever produced. Leaving the grid is always caught by colide first. If colide is wrongly 0 at an edge, the 2-bit field wraps (undefined game state, not checked).
- running and game_over are registered decodes of the state.
- Latency:
  - Button press -> next_dir: 1 clock.
  - next_dir -> direction: at the next commit.
  - Head changes exactly MOVE_PERIOD clocks after entering RUNNING, and every MOVE_PERIOD clocks after that.

Optional Feature:
PAUSE_EN
- Defined: adds input port pause (1 bit).
  - While pause==1 in RUNNING: cnt frozen; no commit, no step, no move_tick.
  - Button capture continues.
  - Release resumes from the frozen cnt.
  - pause has no effect in IDLE or GAME_OVER.
- Undefined: no pause port; cnt runs freely in RUNNING.

Test Plan:
All tests use MOVE_PERIOD=4, START_HEAD=4'b0000, START_DIR=2'b00.
1. Reset low 2 cycles, release, pulse start.
   -> Before start: head=0000, direction=00, running=0, game_over=0.
   -> After start: running=1.
   -> 4 clocks after start: head=0001, with move_tick high for exactly 1 cycle.
2. RUNNING heading RIGHT, pulse btn_left.
   -> direction stays 00.
   -> Then pulse btn_down: direction=10 at the next commit; the following step takes head 0001 -> 0101.
3. Step to head=0011 with direction=00; the checker asserts colide.
   -> At the step point: game_over=1, running=0, head stays 0011, no move_tick.
   -> Then start: IDLE with head=0000.
4. Head=0000, heading RIGHT; btn_up and btn_down high in the same cycle.
   -> next_dir=11 (up wins); commit gives direction=11.
   -> colide=1, then GAME_OVER with head=0000.
5. Drive reset low while head=0101 in RUNNING.
   -> Next edge: head=0000, direction=00, running=0, move_tick=0.
   -> colide pulses ignored until start.
6. (PAUSE_EN) Hold pause=1 for 10 cycles at cnt=1.
   -> head unchanged, no move_tick.
   -> After release, the step occurs 3 clocks later.

Source files
------------

// File: rtl/snake_head_driver_if.sv
// -----------------------------------------------------------------------------
// snake_head_driver_if
//   Bundles the control inputs and the head/status outputs of the snake head
//   driver.
//   master : the game environment (drives start, buttons, colide[, pause]).
//   slave  : snake_head_driver itself (drives head, direction, status flags).
//   Signals:
//     start, btn_right, btn_left, btn_down, btn_up, colide : environment -> driver
//     pause (only when PAUSE_EN is defined)                 : environment -> driver
//     head[3:0], direction[1:0], move_tick, running, game_over : driver -> environment
// -----------------------------------------------------------------------------
interface snake_head_driver_if;
  logic       start;
  logic       btn_right;
  logic       btn_left;
  logic       btn_down;
  logic       btn_up;
  logic       colide;
`ifdef PAUSE_EN
  logic       pause;
`endif
  logic [3:0] head;
  logic [1:0] direction;
  logic       move_tick;
  logic       running;
  logic       game_over;

`ifdef PAUSE_EN
  modport master (
    output start, btn_right, btn_left, btn_down, btn_up, colide, pause,
    input  head, direction, move_tick, running, game_over
  );
  modport slave (
    input  start, btn_right, btn_left, btn_down, btn_up, colide, pause,
    output head, direction, move_tick, running, game_over
  );
`else
  modport master (
    output start, btn_right, btn_left, btn_down, btn_up, colide,
    input  head, direction, move_tick, running, game_over
  );
  modport slave (
    input  start, btn_right, btn_left, btn_down, btn_up, colide,
    output head, direction, move_tick, running, game_over
  );
`endif
endinterface

// File: rtl/snake_head_driver.sv
// -----------------------------------------------------------------------------
// snake_head_driver
//   Owns the snake head cell on the 4x4 grid and the heading. Button presses
//   are captured into next_dir, committed into direction two cycles before
//   each step (so the collision checker can register colide for the new
//   heading), and the head advances one cell every MOVE_PERIOD clocks unless
//   colide ends the game.
//
//   Ports:
//     clock : system clock, rising edge
//     reset : synchronous, active-low
//     bus   : snake_head_driver_if.slave (start, buttons, colide[, pause] in;
//             head, direction, move_tick, running, game_over out)
//
//   Optional feature macro: PAUSE_EN -- adds bus.pause, which freezes the step
//   counter (no commit, no step) while high in RUNNING; button capture goes on.
//
//   Head encoding: [3:2]=row, [1:0]=column.
//   Direction: 00 RIGHT, 01 LEFT, 10 DOWN, 11 UP.
// -----------------------------------------------------------------------------
module snake_head_driver #(
  parameter int unsigned MOVE_PERIOD = 25_000_000,  // must be >= 3
  parameter logic [3:0]  START_HEAD  = 4'b0000,
  parameter logic [1:0]  START_DIR   = 2'b00
) (
  input  logic               clock,
  input  logic               reset,
  snake_head_driver_if.slave bus
);

  localparam int unsigned CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MOVE_PERIOD - 1);
  // Commit two cycles ahead of the step: one cycle for the checker to see
  // the new direction, one for colide to be registered.
  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(MOVE_PERIOD - 3);

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_GAME_OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       head_q;
  logic [1:0]       dir_q;
  logic [1:0]       next_dir_q;
  logic             move_tick_q;
  logic             running_q;
  logic             game_over_q;

  logic [1:0]       cand;
  logic             cand_ok;
  logic [3:0]       step_head;
  logic             advance;

`ifdef PAUSE_EN
  assign advance = ~bus.pause;
`else
  assign advance = 1'b1;
`endif

  // Button candidate (up > down > left > right); a reversal onto the snake's
  // own body (same axis, opposite sense) is rejected.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cand    = DIR_RIGHT;
    cand_ok = 1'b0;
    if (bus.btn_up) begin
      cand    = DIR_UP;
      cand_ok = 1'b1;
    end else if (bus.btn_down) begin
      cand    = DIR_DOWN;
      cand_ok = 1'b1;
    end else if (bus.btn_left) begin
      cand    = DIR_LEFT;
      cand_ok = 1'b1;
    end else if (bus.btn_right) begin
      cand    = DIR_RIGHT;
      cand_ok = 1'b1;
    end
    if (cand[1] == dir_q[1] && cand[0] != dir_q[0])
      cand_ok = 1'b0;
  end

  // Next head cell along the committed direction; 2-bit fields wrap, but the
  // collision checker stops the game before an edge is crossed.
  always_comb begin
    step_head = head_q;
    unique case (dir_t'(dir_q))
      DIR_RIGHT: step_head[1:0] = head_q[1:0] + 2'd1;
      DIR_LEFT:  step_head[1:0] = head_q[1:0] - 2'd1;
      DIR_DOWN:  step_head[3:2] = head_q[3:2] + 2'd1;
      DIR_UP:    step_head[3:2] = head_q[3:2] - 2'd1;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      head_q      <= START_HEAD;
      dir_q       <= START_DIR;
      next_dir_q  <= START_DIR;
      move_tick_q <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      move_tick_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          head_q     <= START_HEAD;
          dir_q      <= START_DIR;
          next_dir_q <= START_DIR;
          if (bus.start) begin
            state     <= ST_RUNNING;
            cnt       <= '0;
            running_q <= 1'b1;
          end
        end

        ST_RUNNING: begin
          if (cand_ok)
            next_dir_q <= cand;
          if (advance) begin
            if (cnt == CNT_COMMIT)
              dir_q <= next_dir_q;
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (bus.colide) begin
                state       <= ST_GAME_OVER;
                running_q   <= 1'b0;
                game_over_q <= 1'b1;
              end else begin
                head_q      <= step_head;
                move_tick_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_GAME_OVER: begin
          if (bus.start) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            head_q      <= START_HEAD;
            dir_q       <= START_DIR;
            next_dir_q  <= START_DIR;
            game_over_q <= 1'b0;
          end
        end

        default: begin
          state       <= ST_IDLE;
          running_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.head      = head_q;
  assign bus.direction = dir_q;
  assign bus.move_tick = move_tick_q;
  assign bus.running   = running_q;
  assign bus.game_over = game_over_q;

endmodule
